// File: rtl/coreboard_ts_capture.sv
// coreboard_ts_capture
//   Captures one timestamped frame of AXIS samples into a double-banked BRAM.
//   The frame layout inside a bank is a 4-word header (RTC second/ns, low
//   half first), followed by samples interleaved as channel-minor,
//   sample-major. Each 32-bit sample is stored as two 16-bit words, lo first.
//
// Ports
//   clk, rst                  sole clock, synchronous active-high reset
//   s_axis_tdata/tvalid/tready  per-channel sample streams (channel c at [32c+:32])
//   rtc_second/rtc_nanosecond   free-running RTC in clk domain
//   ctrl_enable               arm capture (low also clears stat_overrun)
//   ctrl_trigger_source       0 immediate, 1 external, 2 time compare, 3 never
//   ctrl_trigger_second/_nanosecond  compare time for source 2
//   ext_trigger               asynchronous external trigger
//   bram_addr/en/we/din       write-only BRAM port, bank bit is the address MSB
//   frame_irq                 one-cycle pulse per completed frame
//   stat_bank                 bank holding the last completed frame
//   stat_overrun              sticky: trigger seen while a frame was in flight
//   stat_frame_count          completed frames, wraps at 16 bits
module coreboard_ts_capture #(
    parameter int C_NUM_CH          = 4,
    parameter int C_FRAME_SAMPLES   = 64,
    parameter int C_BRAM_ADDR_WIDTH = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [32*C_NUM_CH-1:0]        s_axis_tdata,
    input  logic [C_NUM_CH-1:0]           s_axis_tvalid,
    output logic [C_NUM_CH-1:0]           s_axis_tready,
    input  logic [31:0]                   rtc_second,
    input  logic [31:0]                   rtc_nanosecond,
    input  logic                          ctrl_enable,
    input  logic [1:0]                    ctrl_trigger_source,
    input  logic [31:0]                   ctrl_trigger_second,
    input  logic [31:0]                   ctrl_trigger_nanosecond,
    input  logic                          ext_trigger,
    output logic [C_BRAM_ADDR_WIDTH-1:0]  bram_addr,
    output logic                          bram_en,
    output logic [1:0]                    bram_we,
    output logic [15:0]                   bram_din,
    output logic                          frame_irq,
    output logic                          stat_bank,
    output logic                          stat_overrun,
    output logic [15:0]                   stat_frame_count
);

    localparam int CW = (C_NUM_CH > 1) ? $clog2(C_NUM_CH) : 1;
    localparam int KW = (C_FRAME_SAMPLES > 1) ? $clog2(C_FRAME_SAMPLES) : 1;
    localparam int OW = C_BRAM_ADDR_WIDTH - 1;
    localparam logic [CW-1:0] CH_LAST  = CW'(C_NUM_CH - 1);
    localparam logic [KW-1:0] SMP_LAST = KW'(C_FRAME_SAMPLES - 1);

    typedef enum logic [2:0] {IDLE, HDR, DATA_LO, DATA_HI, DONE} state_t;

    typedef struct packed {
        logic                         en;
        logic [C_BRAM_ADDR_WIDTH-1:0] addr;
        logic [15:0]                  din;
    } bram_wr_t;

    state_t                    state, state_nxt;
    bram_wr_t                  wr;
    logic                      bank;
    logic [CW-1:0]             ch;
    logic [KW-1:0]             smp;
    logic [OW-1:0]             wptr;      // word offset within the bank
    logic [31:0]               sec_q, ns_q;
    logic [15:0]               hi_q;
    logic                      ext_s1, ext_s2, ext_s3;
    logic                      ge_q;
    logic                      overrun_q;
    logic                      stat_bank_q;
    logic [15:0]               frame_cnt_q;

    logic [C_NUM_CH-1:0][31:0] tdata_v;
    logic [31:0]               cur_data;
    logic                      cur_vld;
    logic                      ge, ext_ev, tc_ev, trig_ev, start, take;

    assign tdata_v = s_axis_tdata;

    // Mux of the channel currently expected; loop compare keeps widths exact
    // for any channel count.
    always_comb begin
        cur_data = '0;
        cur_vld  = 1'b0;
        for (int i = 0; i < C_NUM_CH; i++) begin
            if (ch == CW'(i)) begin
                cur_data = tdata_v[i];
                cur_vld  = s_axis_tvalid[i];
            end
        end
    end

    assign ge     = {rtc_second, rtc_nanosecond} >= {ctrl_trigger_second, ctrl_trigger_nanosecond};
    assign ext_ev = ext_s2 & ~ext_s3;
    assign tc_ev  = ge & ~ge_q;

    always_comb begin
        trig_ev = 1'b0;
        case (ctrl_trigger_source)
            2'd0:    trig_ev = (state == IDLE);
            2'd1:    trig_ev = ext_ev;
            2'd2:    trig_ev = tc_ev;
            default: trig_ev = 1'b0;
        endcase
    end

    assign start = (state == IDLE) & ctrl_enable & trig_ev;
    assign take  = (state == DATA_LO) & cur_vld;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        wr            = '0;
        s_axis_tready = '0;
        frame_irq     = 1'b0;
        case (state)
            IDLE: begin
                s_axis_tready = '1;
                if (start) state_nxt = HDR;
            end
            HDR: begin
                wr.en   = 1'b1;
                wr.addr = {bank, wptr};
                case (wptr[1:0])
                    2'd0:    wr.din = sec_q[15:0];
                    2'd1:    wr.din = sec_q[31:16];
                    2'd2:    wr.din = ns_q[15:0];
                    default: wr.din = ns_q[31:16];
                endcase
                if (wptr[1:0] == 2'd3) state_nxt = DATA_LO;
            end
            DATA_LO: begin
                for (int i = 0; i < C_NUM_CH; i++) s_axis_tready[i] = (ch == CW'(i));
                if (cur_vld) begin
                    wr.en     = 1'b1;
                    wr.addr   = {bank, wptr};
                    wr.din    = cur_data[15:0];
                    state_nxt = DATA_HI;
                end
            end
            DATA_HI: begin
                wr.en   = 1'b1;
                wr.addr = {bank, wptr};
                wr.din  = hi_q;
                if (ch == CH_LAST && smp == SMP_LAST) state_nxt = DONE;
                else                                  state_nxt = DATA_LO;
            end
            DONE: begin
                frame_irq = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ext_s1      <= 1'b0;
            ext_s2      <= 1'b0;
            ext_s3      <= 1'b0;
            ge_q        <= 1'b0;
            bank        <= 1'b0;
            ch          <= '0;
            smp         <= '0;
            wptr        <= '0;
            sec_q       <= '0;
            ns_q        <= '0;
            hi_q        <= '0;
            overrun_q   <= 1'b0;
            stat_bank_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            ext_s1 <= ext_trigger;
            ext_s2 <= ext_s1;
            ext_s3 <= ext_s2;
            ge_q   <= ge;

            // Header and data are written in strict address order, so one
            // incrementing pointer yields 4+2*(k*N+c) without a multiplier.
            if (wr.en) wptr <= wptr + 1'b1;

            if (start) begin
                sec_q <= rtc_second;
                ns_q  <= rtc_nanosecond;
                wptr  <= '0;
                ch    <= '0;
                smp   <= '0;
            end

            if (take) hi_q <= cur_data[31:16];

            if (state == DATA_HI) begin
                if (ch == CH_LAST) begin
                    ch  <= '0;
                    smp <= (smp == SMP_LAST) ? '0 : smp + 1'b1;
                end else begin
                    ch  <= ch + 1'b1;
                end
            end

            if (state == DONE) begin
                stat_bank_q <= bank;
                bank        <= ~bank;
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end

            if (!ctrl_enable)                     overrun_q <= 1'b0;
            else if (state != IDLE && trig_ev)    overrun_q <= 1'b1;
        end
    end

    assign bram_en          = wr.en;
    assign bram_we          = {2{wr.en}};
    assign bram_addr        = wr.addr;
    assign bram_din         = wr.din;
    assign stat_bank        = stat_bank_q;
    assign stat_overrun     = overrun_q;
    assign stat_frame_count = frame_cnt_q;

endmodule

// File: tb/tb_coreboard_ts_capture.sv
// Bench for coreboard_ts_capture: N=2 channels, 2 samples/frame, 6-bit BRAM
// address. Drives randomized AXIS streams and compares BRAM contents against
// the frame layout computed directly from channel/sample indices.
module tb_coreboard_ts_capture;
    localparam int N     = 2;
    localparam int S     = 2;
    localparam int AW    = 6;
    localparam int BANK1 = 1 << (AW - 1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [32*N-1:0] s_axis_tdata  = '0;
    logic [N-1:0]    s_axis_tvalid = '0;
    logic [N-1:0]    s_axis_tready;
    logic [31:0]     rtc_second = '0, rtc_nanosecond = '0;
    logic            ctrl_enable = 1'b0;
    logic [1:0]      ctrl_trigger_source = 2'd0;
    logic [31:0]     ctrl_trigger_second = '0, ctrl_trigger_nanosecond = '0;
    logic            ext_trigger = 1'b0;
    logic [AW-1:0]   bram_addr;
    logic            bram_en;
    logic [1:0]      bram_we;
    logic [15:0]     bram_din;
    logic            frame_irq, stat_bank, stat_overrun;
    logic [15:0]     stat_frame_count;

    coreboard_ts_capture #(
        .C_NUM_CH(N), .C_FRAME_SAMPLES(S), .C_BRAM_ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .rtc_second(rtc_second), .rtc_nanosecond(rtc_nanosecond),
        .ctrl_enable(ctrl_enable), .ctrl_trigger_source(ctrl_trigger_source),
        .ctrl_trigger_second(ctrl_trigger_second), .ctrl_trigger_nanosecond(ctrl_trigger_nanosecond),
        .ext_trigger(ext_trigger),
        .bram_addr(bram_addr), .bram_en(bram_en), .bram_we(bram_we), .bram_din(bram_din),
        .frame_irq(frame_irq), .stat_bank(stat_bank), .stat_overrun(stat_overrun),
        .stat_frame_count(stat_frame_count)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int wcnt = 0, irq_cnt = 0, we_bad = 0;
    logic [15:0] mem_obs [0:(1<<AW)-1];
    logic [31:0] q0[$], q1[$];
    logic [31:0] es [N][S];
    logic        feed = 1'b0;
    logic [N-1:0] hold = '0;

    // BRAM model / event monitor
    always @(posedge clk) begin
        if (bram_en) begin
            mem_obs[bram_addr] <= bram_din;
            wcnt <= wcnt + 1;
            if (bram_we !== 2'b11) we_bad <= we_bad + 1;
        end
        if (frame_irq) irq_cnt <= irq_cnt + 1;
    end

    // AXIS sources with random valid gaps
    always @(posedge clk) begin
        if (s_axis_tvalid[0] && s_axis_tready[0] && q0.size() > 0) void'(q0.pop_front());
        if (s_axis_tvalid[1] && s_axis_tready[1] && q1.size() > 0) void'(q1.pop_front());
        #1;
        s_axis_tvalid[0]     = feed && !hold[0] && (q0.size() > 0) && ($urandom_range(0, 2) != 0);
        s_axis_tvalid[1]     = feed && !hold[1] && (q1.size() > 0) && ($urandom_range(0, 2) != 0);
        s_axis_tdata[31:0]   = (q0.size() > 0) ? q0[0] : 32'h0;
        s_axis_tdata[63:32]  = (q1.size() > 0) ? q1[0] : 32'h0;
    end

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_wcnt(input int target, input string tag);
        int b = 0;
        while (wcnt < target && b < 500) begin step(); b++; end
        check(tag, 64'(wcnt >= target), 64'd1);
    endtask

    task automatic wait_irq(input int target, input string tag);
        int b = 0;
        while (irq_cnt < target && b < 1000) begin step(); b++; end
        check(tag, 64'(irq_cnt >= target), 64'd1);
    endtask

    task automatic load_random();
        for (int k = 0; k < S; k++)
            for (int c = 0; c < N; c++) es[c][k] = $urandom;
        for (int k = 0; k < S; k++) begin
            q0.push_back(es[0][k]);
            q1.push_back(es[1][k]);
        end
    endtask

    // Expected frame image from the layout rules: header words, then
    // sample k of channel c at 4+2*(k*N+c) (lo) and +1 (hi).
    task automatic check_frame(input string tag, input int base, input logic [31:0] sec, input logic [31:0] ns);
        logic [15:0] hdr [4];
        hdr[0] = sec[15:0]; hdr[1] = sec[31:16]; hdr[2] = ns[15:0]; hdr[3] = ns[31:16];
        for (int i = 0; i < 4; i++)
            check($sformatf("%s_hdr%0d", tag, i), 64'(mem_obs[base + i]), 64'(hdr[i]));
        for (int k = 0; k < S; k++)
            for (int c = 0; c < N; c++) begin
                check($sformatf("%s_k%0dc%0d_lo", tag, k, c), 64'(mem_obs[base + 4 + 2*(k*N + c)]), 64'(es[c][k][15:0]));
                check($sformatf("%s_k%0dc%0d_hi", tag, k, c), 64'(mem_obs[base + 5 + 2*(k*N + c)]), 64'(es[c][k][31:16]));
            end
    endtask

    // Immediate-source frame: disarm once the header is underway
    task automatic run_immediate(input logic [31:0] sec, input logic [31:0] ns, input int irq_target, input string tag);
        int w0;
        rtc_second = sec; rtc_nanosecond = ns;
        ctrl_trigger_source = 2'd0;
        w0 = wcnt;
        ctrl_enable = 1'b1;
        wait_wcnt(w0 + 1, {tag, "_start"});
        ctrl_enable = 1'b0;
        feed = 1'b1;
        wait_irq(irq_target, {tag, "_irq"});
        feed = 1'b0;
        step(3);
        check({tag, "_nwrites"}, 64'(wcnt - w0), 64'(4 + 2*N*S));
    endtask

    initial begin
        int w0;
        logic [31:0] rs, rn;

        // Reset state
        step(3);
        check("rst_tready", 64'(s_axis_tready), 64'(2'b11));
        check("rst_en", 64'(bram_en), 64'd0);
        check("rst_we", 64'(bram_we), 64'd0);
        check("rst_addr", 64'(bram_addr), 64'd0);
        check("rst_din", 64'(bram_din), 64'd0);
        check("rst_irq", 64'(frame_irq), 64'd0);
        check("rst_bank", 64'(stat_bank), 64'd0);
        check("rst_ovr", 64'(stat_overrun), 64'd0);
        check("rst_cnt", 64'(stat_frame_count), 64'd0);
        rst = 1'b0;
        step(2);

        // Frame 1: directed values
        es[0][0] = 32'h11112222; es[0][1] = 32'h33334444;
        es[1][0] = 32'hAAAABBBB; es[1][1] = 32'hCCCCDDDD;
        for (int k = 0; k < S; k++) begin q0.push_back(es[0][k]); q1.push_back(es[1][k]); end
        run_immediate(32'd5, 32'd100, 1, "f1");
        check_frame("f1", 0, 32'd5, 32'd100);
        check("f1_irqs", 64'(irq_cnt), 64'd1);
        check("f1_bank", 64'(stat_bank), 64'd0);
        check("f1_cnt", 64'(stat_frame_count), 64'd1);

        // Frame 2: random, lands in bank 1
        load_random();
        rs = $urandom; rn = $urandom;
        run_immediate(rs, rn, 2, "f2");
        check_frame("f2", BANK1, rs, rn);
        check("f2_bank", 64'(stat_bank), 64'd1);
        check("f2_cnt", 64'(stat_frame_count), 64'd2);

        // Frame 3: time compare crossing at 10s/0ns
        load_random();
        ctrl_trigger_source = 2'd2;
        ctrl_trigger_second = 32'd10; ctrl_trigger_nanosecond = 32'd0;
        rtc_second = 32'd5; rtc_nanosecond = 32'd0;
        ctrl_enable = 1'b1;
        step(2);
        w0 = wcnt;
        rtc_second = 32'd9; rtc_nanosecond = 32'd999999990;
        step();
        rtc_second = 32'd10; rtc_nanosecond = 32'd0;
        step();
        rtc_nanosecond = 32'd100;
        wait_wcnt(w0 + 1, "f3_start");
        feed = 1'b1;
        wait_irq(3, "f3_irq");
        feed = 1'b0;
        for (int i = 0; i < 40; i++) begin
            rtc_nanosecond = rtc_nanosecond + 32'd1000;
            step();
        end
        check("f3_nwrites", 64'(wcnt - w0), 64'(4 + 2*N*S));
        check("f3_irqs", 64'(irq_cnt), 64'd3);
        check_frame("f3", 0, 32'd10, 32'd0);
        check("f3_bank", 64'(stat_bank), 64'd0);
        check("f3_cnt", 64'(stat_frame_count), 64'd3);
        ctrl_enable = 1'b0;
        step();

        // Frame 4: external trigger, second pulse mid-frame sets overrun
        load_random();
        rs = $urandom; rn = $urandom;
        rtc_second = rs; rtc_nanosecond = rn;
        ctrl_trigger_source = 2'd1;
        ctrl_enable = 1'b1;
        hold = 2'b10;
        step(2);
        w0 = wcnt;
        ext_trigger = 1'b1; step(3); ext_trigger = 1'b0;
        wait_wcnt(w0 + 1, "f4_start");
        feed = 1'b1;
        step(30);
        check("f4_stall_tready", 64'(s_axis_tready), 64'(2'b10));
        check("f4_ovr_pre", 64'(stat_overrun), 64'd0);
        ext_trigger = 1'b1; step(3); ext_trigger = 1'b0; step(3);
        check("f4_ovr_set", 64'(stat_overrun), 64'd1);
        hold = 2'b00;
        wait_irq(4, "f4_irq");
        feed = 1'b0;
        step(30);
        check("f4_nwrites", 64'(wcnt - w0), 64'(4 + 2*N*S));
        check("f4_irqs", 64'(irq_cnt), 64'd4);
        check("f4_ovr_hold", 64'(stat_overrun), 64'd1);
        check_frame("f4", BANK1, rs, rn);
        check("f4_bank", 64'(stat_bank), 64'd1);
        ctrl_enable = 1'b0;
        step();
        check("f4_ovr_clr", 64'(stat_overrun), 64'd0);

        // Stalled channel 1, then reset mid-frame
        load_random();
        hold = 2'b10;
        rtc_second = $urandom;
        ctrl_trigger_source = 2'd0;
        w0 = wcnt;
        ctrl_enable = 1'b1;
        wait_wcnt(w0 + 1, "st_start");
        ctrl_enable = 1'b0;
        feed = 1'b1;
        step(40);
        check("st_tready", 64'(s_axis_tready), 64'(2'b10));
        check("st_irqs", 64'(irq_cnt), 64'd4);
        check("st_cnt", 64'(stat_frame_count), 64'd4);
        rst = 1'b1;
        step();
        check("st_rst_tready", 64'(s_axis_tready), 64'(2'b11));
        check("st_rst_cnt", 64'(stat_frame_count), 64'd0);
        feed = 1'b0; hold = 2'b00;
        q0.delete(); q1.delete();
        step();
        rst = 1'b0;
        step(5);
        check("st_irqs_post", 64'(irq_cnt), 64'd4);
        check("st_tready_post", 64'(s_axis_tready), 64'(2'b11));

        // Source 3: never triggers, samples offered in IDLE are discarded
        ctrl_trigger_source = 2'd3;
        ctrl_enable = 1'b1;
        w0 = wcnt;
        for (int i = 0; i < 4; i++) begin q0.push_back($urandom); q1.push_back($urandom); end
        feed = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ext_trigger = 1'b1; step(3); ext_trigger = 1'b0; step(4);
        end
        step(10);
        check("s3_nwrites", 64'(wcnt - w0), 64'd0);
        check("s3_tready", 64'(s_axis_tready), 64'(2'b11));
        check("s3_irqs", 64'(irq_cnt), 64'd4);
        check("s3_drained", 64'(q0.size() + q1.size()), 64'd0);
        ctrl_enable = 1'b0;
        feed = 1'b0;
        q0.delete(); q1.delete();
        step(2);

        // Frame after reset: bank and count restart
        load_random();
        rs = $urandom; rn = $urandom;
        run_immediate(rs, rn, 5, "f5");
        check_frame("f5", 0, rs, rn);
        check("f5_bank", 64'(stat_bank), 64'd0);
        check("f5_cnt", 64'(stat_frame_count), 64'd1);
        check("we_all_writes", 64'(we_bad), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/coreboard_ts_capture.md
COREBOARD_TS_CAPTURE -- requirements
Module: coreboard_ts_capture

Interface
REQ-001 SHALL have parameter C_NUM_CH, default 4, number of AXIS sample channels (1..8).
REQ-002 SHALL have parameter C_FRAME_SAMPLES, default 64, samples per channel per frame (1..256).
REQ-003 SHALL have parameter C_BRAM_ADDR_WIDTH, default 12, BRAM word-address width; requires 4+2*C_NUM_CH*C_FRAME_SAMPLES <= 2^(C_BRAM_ADDR_WIDTH-1).
REQ-004 SHALL have a single clock and reset: clk  in  1  sole clock; rst  in  1  synchronous, active-high reset.
REQ-005 s_axis_tdata  in  32*C_NUM_CH  per-channel sample, channel c at bits [32c+31:32c].
REQ-006 s_axis_tvalid  in  C_NUM_CH  per-channel valid; s_axis_tready  out  C_NUM_CH  per-channel ready.
REQ-007 rtc_second, rtc_nanosecond  in  32 each  free-running RTC time in clk domain.
REQ-008 ctrl_enable  in  1  arm capture; ctrl_trigger_source  in  2  0=immediate, 1=external, 2=time compare, 3=never.
REQ-009 ctrl_trigger_second, ctrl_trigger_nanosecond  in  32 each  compare time.
REQ-010 ext_trigger  in  1  asynchronous external trigger.
REQ-011 bram_addr  out  C_BRAM_ADDR_WIDTH; bram_en  out  1; bram_we  out  2; bram_din  out  16  write-only BRAM port.
REQ-012 frame_irq  out  1  one-cycle frame-complete pulse; stat_bank  out  1  bank of last completed frame; stat_overrun  out  1  sticky; stat_frame_count  out  16  completed frames.

Function
REQ-013 ext_trigger SHALL pass a 2-flop synchronizer; external event = rising edge of synchronized signal.
REQ-014 Time-compare event SHALL be the cycle where {rtc_second,rtc_nanosecond} >= {ctrl_trigger_second,ctrl_trigger_nanosecond} (64-bit unsigned) becomes true after being false the previous cycle.
REQ-015 Immediate source SHALL produce an event every cycle in IDLE while ctrl_enable=1.
REQ-016 FSM states: IDLE, HDR, DATA_LO, DATA_HI, DONE.
REQ-017 IDLE: s_axis_tready all ones, samples discarded, no BRAM writes; on event with ctrl_enable=1 latch rtc values of that cycle, go HDR.
REQ-018 HDR: 4 consecutive cycles write words 0..3 = second[15:0], second[31:16], ns[15:0], ns[31:16] at bank base.
REQ-019 DATA_LO: s_axis_tready only for expected channel c; on its handshake write tdata[15:0], go DATA_HI; all other tready=0.
REQ-020 DATA_HI: tready=0 all; write held tdata[31:16]; advance c round-robin 0..C_NUM_CH-1, k increments after c wraps.
REQ-021 Sample k of channel c SHALL land at bank offset 4+2*(k*C_NUM_CH+c) (lo), +1 (hi); bank base = bank bit as bram_addr MSB.
REQ-022 After last hi word go DONE: frame_irq=1 one cycle, stat_bank=current bank, bank toggles, stat_frame_count+1 (wraps 0xFFFF->0), return IDLE.
REQ-023 Every write cycle: bram_en=1, bram_we=2'b11; otherwise bram_en=0, bram_we=0.
REQ-024 Event outside IDLE with ctrl_enable=1 SHALL set stat_overrun and be ignored.
REQ-025 ctrl_enable=0 SHALL clear stat_overrun; a frame in progress completes normally.
REQ-026 Channel order is strict; a stalled expected channel stalls the frame, no timeout.

Reset
REQ-027 rst SHALL force IDLE, bank=0, c=k=0, stat_bank=0, stat_overrun=0, stat_frame_count=0, frame_irq=0, bram_en=0, bram_we=0, bram_addr=0, bram_din=0, synchronizer and compare history=0; s_axis_tready all ones next cycle.
REQ-028 rst mid-frame SHALL abandon the frame without irq or count change.

Verification
REQ-029 N=2,S=2, source 0, enable, ch0 sends 0x11112222,0x33334444, ch1 sends 0xAAAABBBB,0xCCCCDDDD, rtc=5s/100ns -> words 0..11 = 0005,0000,0064,0000,2222,1111,BBBB,AAAA,4444,3333,DDDD,CCCC in bank 0, one frame_irq, stat_bank=0, count=1.
REQ-030 Second frame -> written at base 2^(AW-1), stat_bank=1, count=2.
REQ-031 Source 2, compare 10s/0ns, rtc stepping 9s/999999990ns -> 10s/0ns -> header latches 10s/0ns; rtc later stays above -> no retrigger.
REQ-032 Source 1, ext_trigger pulsed during DATA states -> stat_overrun=1, single frame; enable low -> stat_overrun=0.
REQ-033 ch1 tvalid held low -> FSM waits in DATA_LO, ch0 tready=0; rst asserted -> IDLE, no irq, count unchanged.
REQ-034 Source 3 with enable and ext pulses -> no BRAM writes, tready all ones.
